// File: rtl/screen_wr_sched.sv
// Screen RAM write-port scheduler: merges a CPU write FIFO and a linear fill
// engine onto one RAM write port, one slot per clock, CPU bursts capped during fills.
module screen_wr_sched #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CPU_BURST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_wr_req,
    input  logic [ADDR_W-1:0] cpu_wr_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic              cpu_full,
    output logic              cpu_ovf,
    input  logic              cpu_ovf_clr,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int BST_W = $clog2(CPU_BURST + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [BST_W-1:0] BURST_C = BST_W'(CPU_BURST);

    typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_FILL} state_t;

    logic [ADDR_W-1:0] r_mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_full, r_ovf;

    state_t            r_state;
    logic [BST_W-1:0]  r_burst;
    logic              r_wren;
    logic [ADDR_W-1:0] r_wraddr;
    logic [DATA_W-1:0] r_data;

    logic              r_fill_busy, r_fill_done;
    logic [ADDR_W-1:0] r_fill_addr, r_fill_rem;
    logic [DATA_W-1:0] r_fill_val;

    logic              w_push, w_drop, w_empty, w_fill_act;
    logic              w_issue_cpu, w_issue_fill;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_push     = cpu_wr_req && !r_full;
    assign w_drop     = cpu_wr_req && r_full;
    assign w_empty    = (r_cnt == '0);
    // Busy stays high through the cycle the last word is presented; no slots then.
    assign w_fill_act = r_fill_busy && (r_fill_rem != '0);

    always_comb begin
        w_issue_cpu  = 1'b0;
        w_issue_fill = 1'b0;
        w_state_nxt  = ST_IDLE;
        case (r_state)
            ST_CPU: begin
                if (w_fill_act && (r_burst == BURST_C)) w_issue_fill = 1'b1;
                else if (!w_empty)                      w_issue_cpu  = 1'b1;
                else if (w_fill_act)                    w_issue_fill = 1'b1;
            end
            default: begin
                if (!w_empty)        w_issue_cpu  = 1'b1;
                else if (w_fill_act) w_issue_fill = 1'b1;
            end
        endcase
        if (w_issue_cpu)       w_state_nxt = ST_CPU;
        else if (w_issue_fill) w_state_nxt = ST_FILL;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_push && !w_issue_cpu)      w_cnt_nxt = r_cnt + CNT_W'(1);
        else if (!w_push && w_issue_cpu) w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= cpu_wr_addr;
            r_mem_data[r_wr_ptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)      r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_issue_cpu) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == DEPTH_C);
            if (w_drop)           r_ovf <= 1'b1;
            else if (cpu_ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_burst  <= '0;
            r_wren   <= 1'b0;
            r_wraddr <= '0;
            r_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_empty || !w_fill_act || w_issue_fill) r_burst <= '0;
            else if (w_issue_cpu)                       r_burst <= r_burst + BST_W'(1);
            r_wren <= w_issue_cpu || w_issue_fill;
            if (w_issue_cpu) begin
                r_wraddr <= r_mem_addr[r_rd_ptr];
                r_data   <= r_mem_data[r_rd_ptr];
            end else if (w_issue_fill) begin
                r_wraddr <= r_fill_addr;
                r_data   <= r_fill_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill_busy <= 1'b0;
            r_fill_done <= 1'b0;
            r_fill_addr <= '0;
            r_fill_rem  <= '0;
            r_fill_val  <= '0;
        end else begin
            r_fill_done <= 1'b0;
            if (r_fill_busy) begin
                if (r_fill_rem == '0) begin
                    r_fill_busy <= 1'b0;
                    r_fill_done <= 1'b1;
                end else if (w_issue_fill) begin
                    r_fill_addr <= r_fill_addr + ADDR_W'(1);
                    r_fill_rem  <= r_fill_rem - ADDR_W'(1);
                end
            end else if (fill_start) begin
                if (fill_len == '0) begin
                    r_fill_done <= 1'b1;
                end else begin
                    r_fill_busy <= 1'b1;
                    r_fill_addr <= fill_base;
                    r_fill_rem  <= fill_len;
                    r_fill_val  <= fill_val;
                end
            end
        end
    end

    assign cpu_full   = r_full;
    assign cpu_ovf    = r_ovf;
    assign fill_busy  = r_fill_busy;
    assign fill_done  = r_fill_done;
    assign ram_wren   = r_wren;
    assign ram_wraddr = r_wraddr;
    assign ram_data   = r_data;

endmodule
